// File: rtl/mux_scan_reg.sv
// Registered N:1 word multiplexer: direct select, or round-robin scan over enabled channels with a per-channel dwell.
// Capture latency one clk; while out_valid && !out_ready the held word is frozen and the scan stalls at its terminal count.
module mux_scan_reg #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int DWELL = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in,
  input  logic [N-1:0]     ch_en,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             out_valid,
  output logic             scan_wrap
);

  localparam int            CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] nxt;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_found;
  logic [CW-1:0]    cnt;
  logic             free;
  logic             term;
  logic             any_en;
  logic             sel_ok;
  logic [W-1:0]     sel_data;
  logic [W-1:0]     ptr_data;
  logic             cap_dir;
  logic             cap_scan;

  assign free   = !out_valid || out_ready;
  assign term   = (cnt == TERM);
  assign any_en = |ch_en;

  // Explicit compare loop so a select of N..2^SEL_W-1 reads nothing and flags sel_ok low.
  always_comb begin
    sel_data = '0;
    ptr_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in[k*W +: W];
        sel_ok   = 1'b1;
      end
      if (ptr == SEL_W'(k)) begin
        ptr_data = in[k*W +: W];
      end
    end
  end

  // Descending walk: the last hit is the lowest enabled index (overall, and above ptr).
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ch_en[k]) begin
        lo_idx = SEL_W'(k);
        if (k > int'(ptr)) begin
          hi_idx   = SEL_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    nxt = hi_found ? hi_idx : lo_idx;
  end

  assign cap_dir  = !mode && free && sel_ok;
  assign cap_scan = mode && any_en && term && free && ch_en[ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      scan_wrap <= 1'b0;

      if (cap_dir) begin
        out_data  <= sel_data;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else if (cap_scan) begin
        out_data  <= ptr_data;
        out_ch    <= ptr;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Direct mode parks the dwell at zero so re-entering scan restarts a full dwell.
      if (!mode || !any_en) begin
        cnt <= '0;
      end else if (!term) begin
        cnt <= cnt + 1'b1;
      end else if (free) begin
        cnt       <= '0;
        ptr       <= nxt;
        scan_wrap <= (nxt <= ptr);
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: an N=8/W=8/DWELL=2 instance and an N=6/W=4/DWELL=4 instance.
module tb_mux_scan_reg;

  logic        clk;
  logic        rst_n;

  logic        mode_a;
  logic [2:0]  sel_a;
  logic [63:0] in_a;
  logic [7:0]  ch_en_a;
  logic        ready_a;
  logic [7:0]  data_a;
  logic [2:0]  ch_a;
  logic        valid_a;
  logic        wrap_a;

  logic        mode_b;
  logic [2:0]  sel_b;
  logic [23:0] in_b;
  logic [5:0]  ch_en_b;
  logic        ready_b;
  logic [3:0]  data_b;
  logic [2:0]  ch_b;
  logic        valid_b;
  logic        wrap_b;

  int checks;
  int errors;

  mux_scan_reg #(.N(8), .W(8), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a), .in(in_a), .ch_en(ch_en_a),
    .out_ready(ready_a), .out_data(data_a), .out_ch(ch_a), .out_valid(valid_a), .scan_wrap(wrap_a)
  );

  mux_scan_reg #(.N(6), .W(4), .DWELL(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b), .in(in_b), .ch_en(ch_en_b),
    .out_ready(ready_b), .out_data(data_b), .out_ch(ch_b), .out_valid(valid_b), .scan_wrap(wrap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", valid_a); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", data_a); end
    checks++; if (ch_a !== 3'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", ch_a); end
    checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0h exp 0", wrap_a); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0h exp 0", valid_b); end
    rst_n = 1'b1;
  endtask

  task automatic test_direct();
    logic [7:0] exp_d;
    mode_a  = 1'b0;
    ready_a = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel_a = 3'(s);
      exp_d = 8'hA0 + 8'(s);
      @(negedge clk);
      checks++; if (data_a !== exp_d) begin errors++; $display("FAIL direct_data sel=%0d got %0h exp %0h", s, data_a, exp_d); end
      checks++; if (ch_a !== 3'(s)) begin errors++; $display("FAIL direct_ch sel=%0d got %0d exp %0d", s, ch_a, s); end
      checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL direct_valid sel=%0d got %0h exp 1", s, valid_a); end
    end
  endtask

  task automatic test_backpressure();
    sel_a   = 3'd3;
    ready_a = 1'b1;
    @(negedge clk);
    checks++; if (data_a !== 8'hA3) begin errors++; $display("FAIL bp_first got %0h exp a3", data_a); end
    ready_a = 1'b0;
    sel_a   = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (data_a !== 8'hA3 || ch_a !== 3'd3) begin errors++; $display("FAIL bp_hold cyc=%0d got %0h/%0d exp a3/3", i, data_a, ch_a); end
      checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %0h exp 1", i, valid_a); end
    end
    ready_a = 1'b1;
    #1;
    checks++; if (valid_a !== 1'b1 || data_a !== 8'hA3) begin errors++; $display("FAIL bp_accept got %0h/%0h exp 1/a3", valid_a, data_a); end
    @(negedge clk);
    checks++; if (data_a !== 8'hA6 || ch_a !== 3'd6 || valid_a !== 1'b1) begin errors++; $display("FAIL bp_next got %0h/%0d/%0h exp a6/6/1", data_a, ch_a, valid_a); end
  endtask

  task automatic test_scan();
    logic [2:0] seq [6];
    logic [2:0] exp_ch;
    seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd7; seq[4] = 3'd0; seq[5] = 3'd2;
    mode_a  = 1'b1;
    ch_en_a = 8'b1010_0101;
    ready_a = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e % 2 == 0) begin
        exp_ch = seq[e/2 - 1];
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL scan_valid edge=%0d got %0h exp 1", e, valid_a); end
        checks++; if (ch_a !== exp_ch) begin errors++; $display("FAIL scan_ch edge=%0d got %0d exp %0d", e, ch_a, exp_ch); end
        checks++; if (data_a !== 8'hA0 + 8'(exp_ch)) begin errors++; $display("FAIL scan_data edge=%0d got %0h exp %0h", e, data_a, 8'hA0 + 8'(exp_ch)); end
      end else begin
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL scan_idle edge=%0d got %0h exp 0", e, valid_a); end
      end
      checks++; if (wrap_a !== (e == 8)) begin errors++; $display("FAIL scan_wrap edge=%0d got %0h exp %0h", e, wrap_a, (e == 8)); end
    end
  endtask

  task automatic test_no_enable();
    logic exp_v;
    logic exp_w;
    ch_en_a = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (valid_a !== 1'b0 || wrap_a !== 1'b0) begin errors++; $display("FAIL noen cyc=%0d got v=%0h w=%0h exp 0/0", i, valid_a, wrap_a); end
    end
    // ptr sits at 5: first terminal skips 5 and wraps down to 4, then 4 wraps onto itself.
    ch_en_a = 8'h10;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      exp_v = (e == 4 || e == 6);
      exp_w = (e % 2 == 0);
      checks++; if (valid_a !== exp_v) begin errors++; $display("FAIL single_valid edge=%0d got %0h exp %0h", e, valid_a, exp_v); end
      checks++; if (wrap_a !== exp_w) begin errors++; $display("FAIL single_wrap edge=%0d got %0h exp %0h", e, wrap_a, exp_w); end
      if (exp_v) begin
        checks++; if (data_a !== 8'hA4 || ch_a !== 3'd4) begin errors++; $display("FAIL single_data edge=%0d got %0h/%0d exp a4/4", e, data_a, ch_a); end
      end
    end
  endtask

  task automatic test_reset_mid();
    ch_en_a = 8'b1010_0101;
    ready_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (valid_a !== 1'b1 || data_a !== 8'hA4) begin errors++; $display("FAIL stall_hold got %0h/%0h exp 1/a4", valid_a, data_a); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0 || data_a !== 8'h00 || ch_a !== 3'd0 || wrap_a !== 1'b0) begin
      errors++; $display("FAIL midrst got v=%0h d=%0h ch=%0d w=%0h exp 0/00/0/0", valid_a, data_a, ch_a, wrap_a); end
    rst_n   = 1'b1;
    ready_a = 1'b1;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midrst_early got %0h exp 0", valid_a); end
    @(negedge clk);
    checks++; if (valid_a !== 1'b1 || ch_a !== 3'd0 || data_a !== 8'hA0) begin errors++; $display("FAIL midrst_first got %0h/%0d/%0h exp 1/0/a0", valid_a, ch_a, data_a); end
  endtask

  task automatic test_mode_switch();
    @(negedge clk);
    mode_a = 1'b0;
    sel_a  = 3'd7;
    @(negedge clk);
    checks++; if (data_a !== 8'hA7 || ch_a !== 3'd7 || valid_a !== 1'b1) begin errors++; $display("FAIL sw_direct got %0h/%0d/%0h exp a7/7/1", data_a, ch_a, valid_a); end
    mode_a = 1'b1;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL sw_restart got %0h exp 0", valid_a); end
    @(negedge clk);
    checks++; if (valid_a !== 1'b1 || ch_a !== 3'd2 || data_a !== 8'hA2) begin errors++; $display("FAIL sw_scan got %0h/%0d/%0h exp 1/2/a2", valid_a, ch_a, data_a); end
  endtask

  task automatic test_n6();
    mode_b  = 1'b0;
    ready_b = 1'b1;
    sel_b   = 3'd2;
    @(negedge clk);
    checks++; if (data_b !== 4'hB || ch_b !== 3'd2 || valid_b !== 1'b1) begin errors++; $display("FAIL n6_sel2 got %0h/%0d/%0h exp b/2/1", data_b, ch_b, valid_b); end
    sel_b = 3'd6;
    @(negedge clk);
    checks++; if (valid_b !== 1'b0 || data_b !== 4'hB) begin errors++; $display("FAIL n6_sel6 got %0h/%0h exp 0/b", valid_b, data_b); end
    sel_b = 3'd7;
    @(negedge clk);
    checks++; if (valid_b !== 1'b0 || data_b !== 4'hB) begin errors++; $display("FAIL n6_sel7 got %0h/%0h exp 0/b", valid_b, data_b); end
    sel_b = 3'd5;
    @(negedge clk);
    checks++; if (data_b !== 4'hE || ch_b !== 3'd5 || valid_b !== 1'b1) begin errors++; $display("FAIL n6_sel5 got %0h/%0d/%0h exp e/5/1", data_b, ch_b, valid_b); end
    ready_b = 1'b0;
    sel_b   = 3'd6;
    @(negedge clk);
    checks++; if (valid_b !== 1'b1 || data_b !== 4'hE) begin errors++; $display("FAIL n6_stall got %0h/%0h exp 1/e", valid_b, data_b); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    mode_a  = 1'b0;
    sel_a   = 3'd0;
    ch_en_a = 8'h00;
    ready_a = 1'b1;
    mode_b  = 1'b0;
    sel_b   = 3'd0;
    ch_en_b = 6'h00;
    ready_b = 1'b1;
    for (int k = 0; k < 8; k++) in_a[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 6; k++) in_b[k*4 +: 4] = 4'h9 + 4'(k);

    test_reset();
    test_direct();
    test_backpressure();
    test_scan();
    test_no_enable();
    test_reset_mid();
    test_mode_switch();
    test_n6();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
